// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared key-state definitions: key bit indices, scancode prefixes and FSM encodings.
// These macros normally come from DefineMacros.vh; the guards let an existing copy win.
`ifndef NUMBEROFKEYBOARDINPUTS
`define keyTab          0
`define keyQ            1
`define keyW            2
`define keyE            3
`define keyR            4
`define keyT            5
`define keyY            6
`define keyU            7
`define keyI            8
`define keyO            9
`define keyP            10
`define keyLBracket     11
`define keyRBracket     12
`define keyBackslash    13
`define keyNum1         14
`define keyNum2         15
`define keyNum4         16
`define keyNum5         17
`define keyNum6         18
`define keyNum8         19
`define keyNum9         20
`define keyMinus        21
`define keyEquals       22
`define keyBackspace    23
`define keySpace        24
`define keyReleasePulse 25
`define NUMBEROFKEYBOARDINPUTS 26
`endif

`ifndef SC_BREAK
`define SC_BREAK        8'hF0
`define SC_EXTENDED     8'hE0
`define ST_IDLE         2'd0
`define ST_BREAK        2'd1
`define ST_EXT          2'd2
`define ST_EXT_BREAK    2'd3
`endif

package ps2_key_state_tracker_pkg;

  localparam int NUM_KEY_INPUTS    = `NUMBEROFKEYBOARDINPUTS;
  localparam int NUM_TRACKED       = `keyReleasePulse;
  localparam int KEY_RELEASE_PULSE = `keyReleasePulse;
  localparam int KEY_IDX_W         = 5;
  localparam int HELD_W            = 5;

  localparam int KEY_TAB   = `keyTab;
  localparam int KEY_Q     = `keyQ;
  localparam int KEY_1     = `keyNum1;
  localparam int KEY_5     = `keyNum5;
  localparam int KEY_SPACE = `keySpace;

  localparam logic [7:0] SC_BREAK_CODE = `SC_BREAK;
  localparam logic [7:0] SC_EXT_CODE   = `SC_EXTENDED;

  localparam logic [HELD_W-1:0] MAX_HELD = HELD_W'(NUM_TRACKED);

  typedef enum logic [1:0] {
    S_IDLE      = `ST_IDLE,
    S_BREAK     = `ST_BREAK,
    S_EXT       = `ST_EXT,
    S_EXT_BREAK = `ST_EXT_BREAK
  } state_t;

endpackage

// File: rtl/ps2_key_state_tracker_if.sv
// Scancode input and key-state output bundle of the key-state tracker.
// keyPressPulseOut exists only when KEYSTATE_PRESS_PULSE_EN is defined.
interface ps2_key_state_tracker_if;
  import ps2_key_state_tracker_pkg::*;

  logic                      scancodeValid;
  logic [7:0]                scancode;
  logic [NUM_KEY_INPUTS-1:0] inputStateStorage;
  logic [HELD_W-1:0]         keysHeldCount;
`ifdef KEYSTATE_PRESS_PULSE_EN
  logic                      keyPressPulseOut;
`endif

  modport master (
    output scancodeValid, scancode,
`ifdef KEYSTATE_PRESS_PULSE_EN
    input  keyPressPulseOut,
`endif
    input  inputStateStorage, keysHeldCount
  );

  modport slave (
    input  scancodeValid, scancode,
`ifdef KEYSTATE_PRESS_PULSE_EN
    output keyPressPulseOut,
`endif
    output inputStateStorage, keysHeldCount
  );

endinterface

// File: rtl/ps2_key_state_tracker_lookup.sv
// Combinational map from a PS/2 set-2 make code to a tracked key bit index.
// Prefixes and unmapped codes return hit = 0.
module ps2_scancode_lookup
  import ps2_key_state_tracker_pkg::*;
(
  input  logic [7:0]           scancode,
  output logic                 hit,
  output logic [KEY_IDX_W-1:0] keyIndex
);

  int idx;

  always_comb begin
    hit = 1'b1;
    idx = 0;
    case (scancode)
      8'h0D: idx = `keyTab;
      8'h15: idx = `keyQ;
      8'h1D: idx = `keyW;
      8'h24: idx = `keyE;
      8'h2D: idx = `keyR;
      8'h2C: idx = `keyT;
      8'h35: idx = `keyY;
      8'h3C: idx = `keyU;
      8'h43: idx = `keyI;
      8'h44: idx = `keyO;
      8'h4D: idx = `keyP;
      8'h54: idx = `keyLBracket;
      8'h5B: idx = `keyRBracket;
      8'h5D: idx = `keyBackslash;
      8'h16: idx = `keyNum1;
      8'h1E: idx = `keyNum2;
      8'h25: idx = `keyNum4;
      8'h2E: idx = `keyNum5;
      8'h36: idx = `keyNum6;
      8'h3E: idx = `keyNum8;
      8'h46: idx = `keyNum9;
      8'h4E: idx = `keyMinus;
      8'h55: idx = `keyEquals;
      8'h66: idx = `keyBackspace;
      8'h29: idx = `keySpace;
      default: hit = 1'b0;
    endcase
    keyIndex = KEY_IDX_W'(idx);
  end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// PS/2 byte stream (make / F0 break / E0 extended) to registered key-state vector.
// Optional one-cycle press pulse output enabled by defining KEYSTATE_PRESS_PULSE_EN.
module ps2_key_state_tracker
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMEOUT_BITS   = 26
) (
  input logic clk,
  input logic reset,
  ps2_key_state_tracker_if.slave bus
);

  localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                 state, nextState;
  logic [TIMEOUT_BITS-1:0] timeoutCnt;
  logic                   timeoutHit;
  logic                   lookupHit;
  logic [KEY_IDX_W-1:0]   lookupIdx;
  logic [NUM_TRACKED-1:0] keyState;
  logic                   releasePulse;
  logic [HELD_W-1:0]      heldCount;
  logic                   setKey, clearKey;
  logic                   isPrefix;

  ps2_scancode_lookup lookup (
    .scancode (bus.scancode),
    .hit      (lookupHit),
    .keyIndex (lookupIdx)
  );

  assign isPrefix   = (bus.scancode == SC_BREAK_CODE) || (bus.scancode == SC_EXT_CODE);
  assign timeoutHit = (state != S_IDLE) && (timeoutCnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      timeoutCnt <= '0;
    end else begin
      state <= nextState;
      // An accepted byte always restarts the prefix window.
      if (state == S_IDLE || bus.scancodeValid || timeoutHit)
        timeoutCnt <= '0;
      else
        timeoutCnt <= timeoutCnt + 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    if (bus.scancodeValid) begin
      case (state)
        S_IDLE: begin
          if (bus.scancode == SC_BREAK_CODE)    nextState = S_BREAK;
          else if (bus.scancode == SC_EXT_CODE) nextState = S_EXT;
        end
        S_EXT:   nextState = (bus.scancode == SC_BREAK_CODE) ? S_EXT_BREAK : S_IDLE;
        default: nextState = S_IDLE;
      endcase
    end else if (timeoutHit) begin
      nextState = S_IDLE;
    end
  end

  always_comb begin
    setKey   = 1'b0;
    clearKey = 1'b0;
    if (bus.scancodeValid && lookupHit) begin
      if (state == S_IDLE && !isPrefix && !keyState[lookupIdx]) setKey = 1'b1;
      if (state == S_BREAK && keyState[lookupIdx])              clearKey = 1'b1;
    end
  end

  // Output register stage: every output changes one cycle after the accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      keyState     <= '0;
      releasePulse <= 1'b0;
      heldCount    <= '0;
    end else begin
      releasePulse <= clearKey;
      if (setKey) begin
        keyState[lookupIdx] <= 1'b1;
        if (heldCount != MAX_HELD) heldCount <= heldCount + 1'b1;
      end else if (clearKey) begin
        keyState[lookupIdx] <= 1'b0;
        if (heldCount != '0) heldCount <= heldCount - 1'b1;
      end
    end
  end

`ifdef KEYSTATE_PRESS_PULSE_EN
  logic pressPulse;

  always_ff @(posedge clk) begin
    if (reset) pressPulse <= 1'b0;
    else       pressPulse <= setKey;
  end

  assign bus.keyPressPulseOut = pressPulse;
`endif

  always_comb begin
    bus.inputStateStorage                    = '0;
    bus.inputStateStorage[NUM_TRACKED-1:0]   = keyState;
    bus.inputStateStorage[KEY_RELEASE_PULSE] = releasePulse;
  end

  assign bus.keysHeldCount = heldCount;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Scoreboard bench for ps2_key_state_tracker with a shortened prefix timeout.
// Covers KEYSTATE_PRESS_PULSE_EN when that macro is defined for the build.
module tb_ps2_key_state_tracker;
  import ps2_key_state_tracker_pkg::*;

  localparam int TO_CYCLES = 100;

  typedef struct {
    logic [NUM_KEY_INPUTS-1:0] storage;
    logic [HELD_W-1:0]         count;
    logic                      press;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   assertCnt = 0;
  int   failCnt   = 0;
  exp_t sbQ[$];

  // Reference model state
  int                     mState;
  int                     mTo;
  int                     mCount;
  logic [NUM_TRACKED-1:0] mKeys;

  ps2_key_state_tracker_if bus ();

  ps2_key_state_tracker #(
    .TIMEOUT_CYCLES (TO_CYCLES),
    .TIMEOUT_BITS   (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic int keyOf(input logic [7:0] c);
    case (c)
      8'h0D: return 0;   8'h15: return 1;   8'h1D: return 2;   8'h24: return 3;
      8'h2D: return 4;   8'h2C: return 5;   8'h35: return 6;   8'h3C: return 7;
      8'h43: return 8;   8'h44: return 9;   8'h4D: return 10;  8'h54: return 11;
      8'h5B: return 12;  8'h5D: return 13;  8'h16: return 14;  8'h1E: return 15;
      8'h25: return 16;  8'h2E: return 17;  8'h36: return 18;  8'h3E: return 19;
      8'h46: return 20;  8'h4E: return 21;  8'h55: return 22;  8'h66: return 23;
      8'h29: return 24;
      default: return -1;
    endcase
  endfunction

  // Advance the model by one clock and push the outputs expected after it.
  task automatic modelStep(input logic v, input logic [7:0] c, input logic r);
    exp_t e;
    int   k;
    logic rel = 1'b0;
    logic prs = 1'b0;
    if (r) begin
      mState = 0; mTo = 0; mCount = 0; mKeys = '0;
    end else if (v) begin
      k = keyOf(c);
      mTo = 0;
      if (mState == 0) begin
        if (c == 8'hF0) mState = 1;
        else if (c == 8'hE0) mState = 2;
        else if (k >= 0 && !mKeys[k]) begin
          mKeys[k] = 1'b1; prs = 1'b1;
          if (mCount < 25) mCount++;
        end
      end else if (mState == 1) begin
        if (k >= 0 && mKeys[k]) begin
          mKeys[k] = 1'b0; rel = 1'b1;
          if (mCount > 0) mCount--;
        end
        mState = 0;
      end else if (mState == 2) begin
        mState = (c == 8'hF0) ? 3 : 0;
      end else begin
        mState = 0;
      end
    end else if (mState != 0) begin
      if (mTo == TO_CYCLES - 1) begin
        mState = 0; mTo = 0;
      end else begin
        mTo++;
      end
    end
    e.storage = {rel, mKeys};
    e.count   = HELD_W'(mCount);
    e.press   = prs;
    sbQ.push_back(e);
  endtask

  task automatic tick(input logic v, input logic [7:0] c, input logic r = 1'b0);
    exp_t e;
    bus.scancodeValid = v;
    bus.scancode      = c;
    reset             = r;
    @(posedge clk);
    modelStep(v, c, r);
    #1;
    if (sbQ.size() == 0) begin
      checkVal("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkVal("storage", 32'(bus.inputStateStorage), 32'(e.storage));
      checkVal("held", 32'(bus.keysHeldCount), 32'(e.count));
`ifdef KEYSTATE_PRESS_PULSE_EN
      checkVal("press_pulse", 32'(bus.keyPressPulseOut), 32'(e.press));
`endif
    end
  endtask

  task automatic sendBytes(input logic [7:0] codes[$]);
    foreach (codes[i]) tick(1'b1, codes[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] allMakes[$];
    bus.scancodeValid = 1'b0;
    bus.scancode      = 8'h00;
    reset             = 1'b1;
    mState = 0; mTo = 0; mCount = 0; mKeys = '0;

    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h15, 1'b1);
    checkVal("reset_storage", 32'(bus.inputStateStorage), 32'd0);
    checkVal("reset_held", 32'(bus.keysHeldCount), 32'd0);

    // Q press and release
    tick(1'b1, 8'h15);
    checkVal("q_set", 32'(bus.inputStateStorage[KEY_Q]), 32'd1);
    checkVal("q_held", 32'(bus.keysHeldCount), 32'd1);
    sendBytes('{8'hF0, 8'h15});
    checkVal("q_clear", 32'(bus.inputStateStorage[KEY_Q]), 32'd0);
    checkVal("q_rel_pulse", 32'(bus.inputStateStorage[KEY_RELEASE_PULSE]), 32'd1);
    checkVal("q_held0", 32'(bus.keysHeldCount), 32'd0);
    idle(1);
    checkVal("q_pulse_drop", 32'(bus.inputStateStorage[KEY_RELEASE_PULSE]), 32'd0);

    // Typematic Space
    sendBytes('{8'h29, 8'h29, 8'h29});
    checkVal("space_held", 32'(bus.keysHeldCount), 32'd1);
    sendBytes('{8'hF0, 8'h29});
    checkVal("space_rel", 32'(bus.inputStateStorage), 32'(1) << KEY_RELEASE_PULSE);
    idle(2);

    // Extended keys and break of a key never pressed
    sendBytes('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h66});
    checkVal("ext_ignored", 32'(bus.inputStateStorage), 32'd0);
    sendBytes('{8'h16});
    checkVal("idle_after_ext", 32'(bus.inputStateStorage[KEY_1]), 32'd1);
    sendBytes('{8'hF0, 8'h16, 8'hAA, 8'hFA, 8'hEE, 8'hFE});
    checkVal("unmapped", 32'(bus.inputStateStorage), 32'd0);

    // Prefix timeout
    tick(1'b1, 8'hF0);
    idle(TO_CYCLES + 5);
    tick(1'b1, 8'h0D);
    checkVal("timeout_make", 32'(bus.inputStateStorage[KEY_TAB]), 32'd1);
    tick(1'b1, 8'hF0);
    idle(TO_CYCLES / 2);
    tick(1'b1, 8'h0D);
    checkVal("pre_timeout_break", 32'(bus.inputStateStorage[KEY_TAB]), 32'd0);
    sendBytes('{8'h0D, 8'hF0});
    idle(TO_CYCLES - 1);
    tick(1'b1, 8'h0D);
    checkVal("edge_timeout_break", 32'(bus.inputStateStorage[KEY_TAB]), 32'd0);
    tick(1'b1, 8'hF0);
    idle(TO_CYCLES);
    tick(1'b1, 8'h0D);
    checkVal("after_timeout_make", 32'(bus.inputStateStorage[KEY_TAB]), 32'd1);

    // Reset coincident with a make code
    sendBytes('{8'h16, 8'h1E, 8'h25});
    checkVal("held_four", 32'(bus.keysHeldCount), 32'd4);
    tick(1'b1, 8'h2E, 1'b1);
    checkVal("rst_storage", 32'(bus.inputStateStorage), 32'd0);
    checkVal("rst_key5", 32'(bus.inputStateStorage[KEY_5]), 32'd0);
    checkVal("rst_held", 32'(bus.keysHeldCount), 32'd0);

    // Every tracked key held, then released
    allMakes = '{8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h16, 8'h1E, 8'h25, 8'h2E,
                 8'h36, 8'h3E, 8'h46, 8'h4E, 8'h55, 8'h66, 8'h29};
    sendBytes(allMakes);
    sendBytes(allMakes);
    checkVal("all_held", 32'(bus.keysHeldCount), 32'd25);
    checkVal("all_bits", 32'(bus.inputStateStorage), 32'h01FF_FFFF);
    foreach (allMakes[i]) sendBytes('{8'hF0, allMakes[i]});
    checkVal("none_held", 32'(bus.keysHeldCount), 32'd0);
    checkVal("space_last_rel", 32'(bus.inputStateStorage[KEY_SPACE]), 32'd0);

`ifdef KEYSTATE_PRESS_PULSE_EN
    tick(1'b1, 8'h4E);
    checkVal("press_first", 32'(bus.keyPressPulseOut), 32'd1);
    tick(1'b1, 8'h4E);
    checkVal("press_repeat", 32'(bus.keyPressPulseOut), 32'd0);
`endif
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
